// File: rtl/and_mux_arbiter_if.sv
// Handshake and data bundle between two requesters and the shared mux arbiter.
// The master side drives requests and data; the slave side (the arbiter) returns
// grants, the mux select and the muxed data.
interface and_mux_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic [WIDTH-1:0] y;
    logic             valid;

    modport master (
        output req0, req1, d0, d1,
        input  gnt0, gnt1, sel, y, valid
    );

    modport slave (
        input  req0, req1, d0, d1,
        output gnt0, gnt1, sel, y, valid
    );
endinterface

// File: rtl/and_mux_arbiter.sv
// Two-requester arbiter driving a shared 2:1 data mux.
// Ties from IDLE go to the requester not served last; a requester that keeps
// its grant while the other is waiting is preempted after MAX_HOLD cycles.
//
// state | meaning
// IDLE  | no owner, y forced to zero, sel holds its last value
// G0    | requester 0 owns the path, y = d0
// G1    | requester 1 owns the path, y = d1
module and_mux_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4   // legal range 1..255
) (
    input  logic               clk,
    input  logic               rst,
    and_mux_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic       last_q, last_d;     // 1: requester 1 was granted most recently
    logic       sel_q, sel_d;
    logic [7:0] hold_q, hold_d;

    logic       gnt0;
    logic       gnt1;
    logic       valid;

    // State, ownership history, select and hold counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state selection plus bookkeeping on grant entry / retention
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        hold_d  = hold_q;

        case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) state_d = last_q ? G0 : G1;
                else if (bus.req0)        state_d = G0;
                else if (bus.req1)        state_d = G1;
            end
            G0: begin
                if (!bus.req0)                            state_d = bus.req1 ? G1 : IDLE;
                else if (bus.req1 && hold_q == HOLD_MAX)  state_d = G1;
            end
            G1: begin
                if (!bus.req1)                            state_d = bus.req0 ? G0 : IDLE;
                else if (bus.req0 && hold_q == HOLD_MAX)  state_d = G0;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            hold_d = 8'd0;
        end else if (state_d != state_q) begin
            hold_d = 8'd1;
            last_d = (state_d == G1);
            sel_d  = (state_d == G1);
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 8'd1;
        end
    end

    assign gnt0  = (state_q == G0);
    assign gnt1  = (state_q == G1);
    assign valid = gnt0 | gnt1;

    assign bus.gnt0  = gnt0;
    assign bus.gnt1  = gnt1;
    assign bus.valid = valid;
    assign bus.sel   = sel_q;

    // Shared data mux, zero whenever nobody owns the path
    always_comb begin
        bus.y = {WIDTH{1'b0}};
        if (valid) bus.y = sel_q ? bus.d1 : bus.d0;
    end

endmodule

// File: tb/tb_and_mux_arbiter.sv
// Directed bench for and_mux_arbiter with WIDTH=8, MAX_HOLD=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_and_mux_arbiter;

    logic clk;
    logic rst;

    int n_vec  = 0;
    int n_miss = 0;

    and_mux_arbiter_if #(.WIDTH(8)) bus ();

    and_mux_arbiter #(
        .WIDTH    (8),
        .MAX_HOLD (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks all grant-side outputs against one expected owner code:
    // 0 = idle, 1 = requester 0, 2 = requester 1; exp_sel used for sel.
    task automatic chk_owner(input string tag, input int owner, input logic exp_sel);
        chk({tag, ".gnt0"},  {31'd0, bus.gnt0},  {31'd0, owner == 1});
        chk({tag, ".gnt1"},  {31'd0, bus.gnt1},  {31'd0, owner == 2});
        chk({tag, ".valid"}, {31'd0, bus.valid}, {31'd0, owner != 0});
        chk({tag, ".sel"},   {31'd0, bus.sel},   {31'd0, exp_sel});
        chk({tag, ".y"},     {24'd0, bus.y},
            (owner == 1) ? 32'hA5 : (owner == 2) ? 32'h3C : 32'h00);
    endtask

    // Owner sequence with both requests held after reset release:
    // G0 x4, G1 x4, G0 x4, G1 x4, G0 (fresh entry)
    int both_seq [17] = '{1,1,1,1, 2,2,2,2, 1,1,1,1, 2,2,2,2, 1};

    initial begin
        rst      = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.d0   = 8'hA5;
        bus.d1   = 8'h3C;

        // Reset state while both requests are asserted
        @(negedge clk);
        @(negedge clk);
        chk_owner("reset", 0, 1'b0);

        // Release reset; tie goes to requester 0, then alternation every 4 cycles
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            chk_owner($sformatf("both[%0d]", i), both_seq[i], both_seq[i] == 2);
            chk($sformatf("both[%0d].excl", i), {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
        end

        // In G0 (fresh entry), req0 drops while req1 is high: direct handover
        bus.req0 = 1'b0;
        @(negedge clk);
        chk_owner("handover", 2, 1'b1);

        // Both drop: idle, sel keeps 1
        bus.req1 = 1'b0;
        @(negedge clk);
        chk_owner("idle_after_g1", 0, 1'b1);

        // Raising requests between edges must not reach the grant combinationally
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        #1;
        chk("no_comb_path.gnt0", {31'd0, bus.gnt0}, 32'd0);
        chk("no_comb_path.gnt1", {31'd0, bus.gnt1}, 32'd0);

        // Tie after serving requester 1 goes to requester 0
        @(negedge clk);
        chk_owner("tie_after_g1", 1, 1'b0);

        // Both drop, then tie after serving requester 0 goes to requester 1
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        chk_owner("idle_after_g0", 0, 1'b0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        @(negedge clk);
        chk_owner("tie_after_g0", 2, 1'b1);

        // Back to idle, then requester 1 alone for 10 cycles: no preemption
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        chk_owner("idle_pre_solo", 0, 1'b1);
        bus.req1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_owner($sformatf("solo1[%0d]", i), 2, 1'b1);
        end

        // Asynchronous reset pulse mid-grant, between clock edges
        #1;
        rst = 1'b1;
        #1;
        chk_owner("async_rst", 0, 1'b0);
        #1;
        rst = 1'b0;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        @(negedge clk);
        chk_owner("tie_after_rst", 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
